// File: rtl/ff_pkg.sv
// rtl/ff_pkg.sv - shared mode encoding and next-state function for the flip-flop bank
package ff_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } mode_t;

  // Next q of one enabled bit; a is D/T/J/S and b is K/R.
  // SR with S=R=1 holds here; flagging it is the cell's job.
  function automatic logic ff_next(input mode_t m, input logic q, input logic a, input logic b);
    logic n;
    n = q;
    unique case (m)
      MODE_D:  n = a;
      MODE_T:  n = a ? ~q : q;
      MODE_JK: begin
        unique case ({a, b})
          2'b00:   n = q;
          2'b01:   n = 1'b0;
          2'b10:   n = 1'b1;
          default: n = ~q;
        endcase
      end
      default: begin
        unique case ({a, b})
          2'b01:   n = 1'b0;
          2'b10:   n = 1'b1;
          default: n = q;
        endcase
      end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ff_bit_cell.sv
// rtl/ff_bit_cell.sv - one flip-flop bit with its own mode register, edge pulses and illegal flag
module ff_bit_cell
  import ff_pkg::*;
#(
  parameter logic  RESET_Q    = 1'b0,
  parameter mode_t RESET_MODE = MODE_D
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cfg_we,
  input  logic [1:0] cfg_mode,
  input  logic       en,
  input  logic       clr,
  input  logic       load,
  input  logic       load_val,
  input  logic       a,
  input  logic       b,
  input  logic       illegal_clr,
  output logic       q,
  output logic       q_rise,
  output logic       q_fall,
  output logic [1:0] mode,
  output logic       illegal,
  output logic       illegal_evt
);

  logic  q_q, q_d;
  logic  rise_q, rise_d;
  logic  fall_q, fall_d;
  logic  illegal_q, illegal_d;
  mode_t mode_q, mode_d;

  // Next state: clr beats load beats en; the datapath always sees the mode held before this edge.
  always_comb begin
    q_d         = q_q;
    mode_d      = mode_q;
    illegal_evt = 1'b0;
    if (clr) begin
      q_d = RESET_Q;
    end else if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d         = ff_next(mode_q, q_q, a, b);
      illegal_evt = (mode_q == MODE_SR) && a && b;
    end
    if (cfg_we) begin
      mode_d = mode_t'(cfg_mode);
    end
    rise_d    = q_d & ~q_q;
    fall_d    = ~q_d & q_q;
    illegal_d = illegal_evt | (illegal_q & ~illegal_clr);
  end

  // State registers; reset drops everything at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q       <= RESET_Q;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      illegal_q <= 1'b0;
      mode_q    <= RESET_MODE;
    end else begin
      q_q       <= q_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      illegal_q <= illegal_d;
      mode_q    <= mode_d;
    end
  end

  assign q       = q_q;
  assign q_rise  = rise_q;
  assign q_fall  = fall_q;
  assign mode    = mode_q;
  assign illegal = illegal_q;

endmodule

// File: rtl/ff_bank_multimode.sv
// rtl/ff_bank_multimode.sv - WIDTH-bit multimode flip-flop bank with saturating SR-illegal counter
module ff_bank_multimode
  import ff_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = 8'h00,
  parameter logic [1:0]       RESET_MODE = 2'b00,
  parameter int               CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_we,
  input  logic [WIDTH-1:0]     cfg_mask,
  input  logic [1:0]           cfg_mode,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     q_rise,
  output logic [WIDTH-1:0]     q_fall,
  output logic [2*WIDTH-1:0]   mode,
  output logic [WIDTH-1:0]     illegal,
  input  logic [WIDTH-1:0]     illegal_clr,
  output logic [CNT_W-1:0]     illegal_cnt
);

  logic [WIDTH-1:0] evt_vec;
  logic             any_evt;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ff_bit_cell #(
      .RESET_Q    (RESET_VAL[i]),
      .RESET_MODE (mode_t'(RESET_MODE))
    ) u_cell (
      .clk         (clk),
      .reset_n     (reset_n),
      .cfg_we      (cfg_we & cfg_mask[i]),
      .cfg_mode    (cfg_mode),
      .en          (en),
      .clr         (clr),
      .load        (load),
      .load_val    (load_val[i]),
      .a           (a[i]),
      .b           (b[i]),
      .illegal_clr (illegal_clr[i]),
      .q           (q[i]),
      .q_rise      (q_rise[i]),
      .q_fall      (q_fall[i]),
      .mode        (mode[2*i +: 2]),
      .illegal     (illegal[i]),
      .illegal_evt (evt_vec[i])
    );
  end

  // One count per edge with any new illegal event, saturating at all-ones.
  always_comb begin
    any_evt = |evt_vec;
    cnt_d   = cnt_q;
    if (any_evt && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_ff_bank_multimode.sv
// tb/tb_ff_bank_multimode.sv - randomized and directed bench with behavioural reference model
module tb_ff_bank_multimode;

  localparam logic [7:0] RV = 8'h00;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_we;
  logic [7:0]  cfg_mask;
  logic [1:0]  cfg_mode;
  logic        en, clr, load;
  logic [7:0]  load_val, a, b, illegal_clr;
  logic [7:0]  q, q_rise, q_fall, illegal;
  logic [15:0] mode;
  logic [7:0]  illegal_cnt;

  ff_bank_multimode dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_mask(cfg_mask),
    .cfg_mode(cfg_mode), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .a(a), .b(b), .q(q), .q_rise(q_rise), .q_fall(q_fall), .mode(mode),
    .illegal(illegal), .illegal_clr(illegal_clr), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  // reference state
  logic [7:0]  m_q, m_rise, m_fall, m_ill;
  logic [15:0] m_mode;
  int          m_cnt;
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = RV; m_rise = 0; m_fall = 0; m_ill = 0; m_mode = 16'h0000; m_cnt = 0;
  endtask

  task automatic idle();
    cfg_we = 0; cfg_mask = 0; cfg_mode = 0; en = 0; clr = 0; load = 0;
    load_val = 0; a = 0; b = 0; illegal_clr = 0;
  endtask

  // One clock edge: next state from vector arithmetic over per-mode bit masks.
  task automatic tick();
    logic [7:0]  dm, tm, jm, sm, nq, ev, nen;
    logic [15:0] nmode;
    for (int i = 0; i < 8; i++) begin
      dm[i] = (m_mode[2*i +: 2] == 2'd0);
      tm[i] = (m_mode[2*i +: 2] == 2'd1);
      jm[i] = (m_mode[2*i +: 2] == 2'd2);
      sm[i] = (m_mode[2*i +: 2] == 2'd3);
    end
    nen = (a & dm) | ((m_q ^ a) & tm) | (((a & ~m_q) | (~b & m_q)) & jm)
        | (((a & ~b) | (m_q & ~(~a & b))) & sm);
    if (clr)       nq = RV;
    else if (load) nq = load_val;
    else if (en)   nq = nen;
    else           nq = m_q;
    ev = (en && !clr && !load) ? (sm & a & b) : 8'h00;
    nmode = m_mode;
    if (cfg_we)
      for (int i = 0; i < 8; i++) if (cfg_mask[i]) nmode[2*i +: 2] = cfg_mode;
    @(posedge clk);
    m_rise = nq & ~m_q;
    m_fall = ~nq & m_q;
    m_q    = nq;
    m_ill  = ev | (m_ill & ~illegal_clr);
    if (ev != 0 && m_cnt < 255) m_cnt++;
    m_mode = nmode;
    @(negedge clk);
    #1;
    idle();
  endtask

  task automatic cfg_all(input logic [7:0] mask, input logic [1:0] md);
    cfg_we = 1; cfg_mask = mask; cfg_mode = md;
    tick();
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("q", 32'(q), 32'(m_q));
      chk("q_rise", 32'(q_rise), 32'(m_rise));
      chk("q_fall", 32'(q_fall), 32'(m_fall));
      chk("mode", 32'(mode), 32'(m_mode));
      chk("illegal", 32'(illegal), 32'(m_ill));
      chk("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
    end
  end

  task automatic rand_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      cfg_we      = ($urandom_range(0, 7) == 0);
      cfg_mask    = 8'($urandom);
      cfg_mode    = 2'($urandom);
      en          = ($urandom_range(0, 3) != 0);
      clr         = ($urandom_range(0, 15) == 0);
      load        = ($urandom_range(0, 15) == 0);
      load_val    = 8'($urandom);
      a           = 8'($urandom);
      b           = 8'($urandom);
      illegal_clr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      tick();
    end
  endtask

  initial begin
    idle();
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_cnt", 32'(illegal_cnt), 32'h00);
    #1;
    reset_n = 1;

    // D mode
    cfg_all(8'hFF, 2'd0);
    en = 1; a = 8'hA5; tick();
    chk("d_q", 32'(q), 32'hA5);
    chk("d_rise", 32'(q_rise), 32'hA5);

    // T mode from q=0
    clr = 1; tick();
    cfg_all(8'hFF, 2'd1);
    en = 1; a = 8'h0F; tick();
    chk("t_q1", 32'(q), 32'h0F);
    en = 1; a = 8'h0F; tick();
    chk("t_q2", 32'(q), 32'h00);
    chk("t_fall2", 32'(q_fall), 32'h0F);
    en = 1; a = 8'h0F; tick();
    chk("t_q3", 32'(q), 32'h0F);

    // JK low nibble, SR high nibble
    clr = 1; tick();
    cfg_all(8'h0F, 2'd2);
    cfg_all(8'hF0, 2'd3);
    en = 1; a = 8'hFF; b = 8'hFF; tick();
    chk("jksr_q", 32'(q), 32'h0F);
    chk("jksr_ill", 32'(illegal), 32'hF0);
    chk("jksr_cnt", 32'(illegal_cnt), 32'd1);
    for (int k = 0; k < 260; k++) begin
      en = 1; a = 8'hFF; b = 8'hFF; tick();
    end
    chk("cnt_sat", 32'(illegal_cnt), 32'd255);

    // priority clr > load > en
    clr = 1; load = 1; en = 1; load_val = 8'h3C; a = 8'hFF; tick();
    chk("prio_clr", 32'(q), 32'(RV));
    load = 1; en = 1; load_val = 8'h3C; a = 8'hFF; b = 8'h00; tick();
    chk("prio_load", 32'(q), 32'h3C);

    // mode write coinciding with D data
    clr = 1; tick();
    cfg_all(8'hFF, 2'd0);
    cfg_we = 1; cfg_mask = 8'hFF; cfg_mode = 2'd1; en = 1; a = 8'h0F; tick();
    chk("mw_old", 32'(q), 32'h0F);
    en = 1; a = 8'h0F; tick();
    chk("mw_new", 32'(q), 32'h00);

    // illegal_clr vs new event
    cfg_all(8'hFF, 2'd3);
    illegal_clr = 8'hFF; tick();
    chk("ill_cleared", 32'(illegal), 32'h00);
    en = 1; a = 8'h01; b = 8'h01; illegal_clr = 8'h01; tick();
    chk("ill_setwins", 32'(illegal), 32'h01);
    illegal_clr = 8'h01; tick();
    chk("ill_w1c", 32'(illegal), 32'h00);

    // random traffic
    rand_ticks(300);

    // asynchronous reset between edges
    @(posedge clk);
    #2;
    reset_n = 0;
    model_reset();
    #1;
    chk("async_q", 32'(q), 32'(RV));
    chk("async_mode", 32'(mode), 32'h0000);
    chk("async_ill", 32'(illegal), 32'h00);
    chk("async_cnt", 32'(illegal_cnt), 32'h00);
    chk("async_pulse", 32'({q_rise, q_fall}), 32'h0000);
    @(negedge clk);
    @(negedge clk);
    #1;
    reset_n = 1;
    rand_ticks(200);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
